// File: rtl/mul_acc.sv
// Pipelined multiply-accumulate: PIPE product stages feeding a saturating
// group accumulator with a single-entry output register and backpressure.
module mul_acc #(
   parameter int A     = 8,
   parameter int B     = 8,
   parameter int ACC_W = 32,
   parameter int PIPE  = 2
) (
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A-1:0]     in_a,
   input  logic [B-1:0]     in_b,
   input  logic             in_signed,
   input  logic             in_first,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf
);

   localparam int PW = A + B;
   localparam int XW = ACC_W - PW;

   // Handshake: a beat moves on any edge where in_valid && in_ready, a result
   // leaves on any edge where out_valid && out_ready. in_ready depends
   // combinationally on out_ready through the stall term.

   logic [PW-1:0] a_wide;
   logic [PW-1:0] b_wide;
   logic [PW-1:0] prod_in;

   // Extending both operands to the full product width lets one unsigned
   // multiply yield the correct low PW bits for either signedness.
   assign a_wide  = {{B{in_signed & in_a[A-1]}}, in_a};
   assign b_wide  = {{A{in_signed & in_b[B-1]}}, in_b};
   assign prod_in = a_wide * b_wide;

   logic [PIPE-1:0] st_valid;
   logic [PIPE-1:0] st_first;
   logic [PIPE-1:0] st_last;
   logic [PIPE-1:0] st_signed;
   logic [PW-1:0]   st_prod [PIPE];

   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic             stall;
   logic             step;
   logic [PW-1:0]    p_top;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] base;
   logic [ACC_W:0]   sum;
   logic             sat;
   logic [ACC_W-1:0] clamped;
   logic             ovf_next;

   assign p_top    = st_prod[PIPE-1];
   assign stall    = out_valid && !out_ready && st_valid[PIPE-1] && st_last[PIPE-1];
   assign in_ready = !stall;
   assign step     = st_valid[PIPE-1] && !stall;

   always_comb begin
      prod_ext = st_signed[PIPE-1] ? {{XW{p_top[PW-1]}}, p_top} : {{XW{1'b0}}, p_top};
      base     = st_first[PIPE-1] ? '0 : acc;
      sum      = {base[ACC_W-1], base} + {prod_ext[ACC_W-1], prod_ext};
      // The two top bits of the widened sum disagree exactly when it left range.
      sat      = sum[ACC_W] ^ sum[ACC_W-1];
      clamped  = sum[ACC_W-1:0];
      if (sat) begin
         clamped = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
      ovf_next = (!st_first[PIPE-1] && ovf) || sat;
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         st_valid  <= '0;
         st_first  <= '0;
         st_last   <= '0;
         st_signed <= '0;
         for (int i = 0; i < PIPE; i++) begin
            st_prod[i] <= '0;
         end
      end else if (!stall) begin
         st_valid[0]  <= in_valid;
         st_first[0]  <= in_first;
         st_last[0]   <= in_last;
         st_signed[0] <= in_signed;
         st_prod[0]   <= prod_in;
         for (int i = 1; i < PIPE; i++) begin
            st_valid[i]  <= st_valid[i-1];
            st_first[i]  <= st_first[i-1];
            st_last[i]   <= st_last[i-1];
            st_signed[i] <= st_signed[i-1];
            st_prod[i]   <= st_prod[i-1];
         end
      end
   end

   // A closing beat leaves acc/ovf at zero so an unframed follow-on beat starts clean.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (step) begin
         if (st_last[PIPE-1]) begin
            acc <= '0;
            ovf <= 1'b0;
         end else begin
            acc <= clamped;
            ovf <= ovf_next;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_ovf   <= 1'b0;
      end else if (step && st_last[PIPE-1]) begin
         out_valid <= 1'b1;
         out_acc   <= clamped;
         out_ovf   <= ovf_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
